// File: rtl/qspi_psram_ctrl.sv
// QSPI PSRAM master: runs the 0x66/0x99 reset sequence, then serves single-word
// quad writes (0x38) and fast quad reads (0xEB) for a simple req/ack requester.
module qspi_psram_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int RD_WAIT  = 6,
    parameter int CE_GAP   = 4,
    parameter int INIT_DLY = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [23:0] adr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        init_done,
    output logic        psram_sck,
    output logic        psram_ce_n,
    output logic [3:0]  sio_out,
    output logic        sio_oe,
    input  logic [3:0]  sio_in
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [7:0] CMD_RSTEN = 8'h66;
    localparam logic [7:0] CMD_RST   = 8'h99;
    localparam logic [7:0] CMD_WRITE = 8'h38;
    localparam logic [7:0] CMD_READ  = 8'hEB;

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_RSTEN     = 4'd1;
    localparam logic [3:0] S_RST       = 4'd2;
    localparam logic [3:0] S_GAP       = 4'd3;
    localparam logic [3:0] S_IDLE      = 4'd4;
    localparam logic [3:0] S_CMD       = 4'd5;
    localparam logic [3:0] S_ADR       = 4'd6;
    localparam logic [3:0] S_WDAT      = 4'd7;
    localparam logic [3:0] S_RWAIT     = 4'd8;
    localparam logic [3:0] S_RDAT      = 4'd9;

    logic [3:0]       state_reg, state_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             sck_reg, sck_next;
    logic [3:0]       bit_reg, bit_next;
    logic [15:0]      dly_reg, dly_next;
    logic             gap_rst_reg, gap_rst_next;
    logic             ce_n_reg, ce_n_next;
    logic [3:0]       sio_out_reg, sio_out_next;
    logic             sio_oe_reg, sio_oe_next;
    logic             ack_reg, ack_next;
    logic             busy_reg, busy_next;
    logic             init_done_reg, init_done_next;
    logic [31:0]      rdata_reg, rdata_next;
    logic             we_reg, we_next;
    logic [23:0]      adr_reg, adr_next;
    logic [31:0]      txd_reg, txd_next;
    logic [31:0]      rx_reg, rx_next;

    logic             shifting, div_last, sck_rise, sck_fall, shift_done;
    logic [7:0]       cmd_byte;
    logic [31:0]      adr_word;
    logic [4:0]       nib_idx;

    function automatic logic is_shift(input logic [3:0] s);
        return (s == S_RSTEN) || (s == S_RST) || (s == S_CMD) || (s == S_ADR) ||
               (s == S_WDAT) || (s == S_RWAIT) || (s == S_RDAT);
    endfunction

    assign shifting   = is_shift(state_reg);
    assign div_last   = (div_reg == DIV_LAST);
    assign sck_rise   = shifting && div_last && !sck_reg;
    assign sck_fall   = shifting && div_last && sck_reg;
    assign shift_done = sck_fall && (bit_reg == 4'd0);

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        sck_next       = sck_reg;
        bit_next       = bit_reg;
        dly_next       = dly_reg;
        gap_rst_next   = gap_rst_reg;
        ack_next       = 1'b0;
        rdata_next     = rdata_reg;
        init_done_next = init_done_reg;
        we_next        = we_reg;
        adr_next       = adr_reg;
        txd_next       = txd_reg;
        rx_next        = rx_reg;

        if (shifting) begin
            div_next = div_last ? '0 : div_reg + 1'b1;
            if (div_last)
                sck_next = ~sck_reg;
        end
        if (sck_fall && (bit_reg != 4'd0))
            bit_next = bit_reg - 4'd1;
        // Read nibbles are taken on the clk where SCK rises, mid data-valid window.
        if (sck_rise && (state_reg == S_RDAT))
            rx_next = {rx_reg[27:0], sio_in};

        case (state_reg)
            S_INIT_WAIT: begin
                if (dly_reg == 16'd0) state_next = S_RSTEN;
                else                  dly_next   = dly_reg - 16'd1;
            end
            S_GAP: begin
                if (dly_reg == 16'd0) state_next = gap_rst_reg ? S_RST : S_IDLE;
                else                  dly_next   = dly_reg - 16'd1;
            end
            S_IDLE: begin
                if (req && init_done_reg) begin
                    state_next = S_CMD;
                    we_next    = we;
                    adr_next   = adr & 24'hFF_FFFC;
                    // Byte-swapped so the nibble stream is a plain MSB-first walk.
                    txd_next   = {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]};
                end
            end
            S_RSTEN: if (shift_done) begin state_next = S_GAP; gap_rst_next = 1'b1; end
            S_RST:   if (shift_done) begin state_next = S_GAP; gap_rst_next = 1'b0; end
            S_CMD:   if (shift_done) state_next = S_ADR;
            S_ADR:   if (shift_done) state_next = we_reg ? S_WDAT : S_RWAIT;
            S_RWAIT: if (shift_done) state_next = S_RDAT;
            S_WDAT: begin
                if (shift_done) begin
                    state_next   = S_GAP;
                    gap_rst_next = 1'b0;
                    ack_next     = 1'b1;
                end
            end
            S_RDAT: begin
                if (shift_done) begin
                    state_next   = S_GAP;
                    gap_rst_next = 1'b0;
                    ack_next     = 1'b1;
                    rdata_next   = {rx_reg[7:0], rx_reg[15:8], rx_reg[23:16], rx_reg[31:24]};
                end
            end
            default: state_next = S_INIT_WAIT;
        endcase

        // Counters reload on every state entry so they never wrap inside a state.
        if (state_next != state_reg) begin
            div_next = '0;
            sck_next = 1'b0;
            case (state_next)
                S_RSTEN, S_RST, S_CMD, S_WDAT, S_RDAT: bit_next = 4'd7;
                S_ADR:       bit_next = 4'd5;
                S_RWAIT:     bit_next = 4'(RD_WAIT - 1);
                S_GAP:       dly_next = 16'(CE_GAP - 1);
                S_INIT_WAIT: dly_next = 16'(INIT_DLY - 1);
                S_IDLE:      init_done_next = 1'b1;
                default:     bit_next = bit_reg;
            endcase
        end
    end

    // Pad values follow the next state, so they change only at SCK fall or entry.
    assign cmd_byte = we_next ? CMD_WRITE : CMD_READ;
    assign adr_word = {8'h00, adr_next};
    assign nib_idx  = {bit_next[2:0], 2'b00};

    always_comb begin
        sio_out_next = 4'h0;
        sio_oe_next  = 1'b1;
        case (state_next)
            S_RSTEN: sio_out_next = {3'b000, CMD_RSTEN[bit_next[2:0]]};
            S_RST:   sio_out_next = {3'b000, CMD_RST[bit_next[2:0]]};
            S_CMD:   sio_out_next = {3'b000, cmd_byte[bit_next[2:0]]};
            S_ADR:   sio_out_next = adr_word[nib_idx +: 4];
            S_WDAT:  sio_out_next = txd_next[nib_idx +: 4];
            default: sio_oe_next  = 1'b0;
        endcase
        ce_n_next = !is_shift(state_next);
        busy_next = (state_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_INIT_WAIT;
            div_reg       <= '0;
            sck_reg       <= 1'b0;
            bit_reg       <= 4'd0;
            dly_reg       <= 16'(INIT_DLY - 1);
            gap_rst_reg   <= 1'b0;
            ce_n_reg      <= 1'b1;
            sio_out_reg   <= 4'h0;
            sio_oe_reg    <= 1'b0;
            ack_reg       <= 1'b0;
            busy_reg      <= 1'b1;
            init_done_reg <= 1'b0;
            rdata_reg     <= 32'h0;
            we_reg        <= 1'b0;
            adr_reg       <= 24'h0;
            txd_reg       <= 32'h0;
            rx_reg        <= 32'h0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            sck_reg       <= sck_next;
            bit_reg       <= bit_next;
            dly_reg       <= dly_next;
            gap_rst_reg   <= gap_rst_next;
            ce_n_reg      <= ce_n_next;
            sio_out_reg   <= sio_out_next;
            sio_oe_reg    <= sio_oe_next;
            ack_reg       <= ack_next;
            busy_reg      <= busy_next;
            init_done_reg <= init_done_next;
            rdata_reg     <= rdata_next;
            we_reg        <= we_next;
            adr_reg       <= adr_next;
            txd_reg       <= txd_next;
            rx_reg        <= rx_next;
        end
    end

    assign rdata      = rdata_reg;
    assign ack        = ack_reg;
    assign busy       = busy_reg;
    assign init_done  = init_done_reg;
    assign psram_sck  = sck_reg;
    assign psram_ce_n = ce_n_reg;
    assign sio_out    = sio_out_reg;
    assign sio_oe     = sio_oe_reg;

endmodule

// File: tb/tb_qspi_psram_ctrl.sv
// Directed bench for qspi_psram_ctrl with a protocol-level PSRAM model that
// decodes the serial stream, stores written words and answers quad reads.
module tb_qspi_psram_ctrl;

    localparam int CLK_DIV  = 2;
    localparam int RD_WAIT  = 6;
    localparam int CE_GAP   = 4;
    localparam int INIT_DLY = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [23:0] adr = 24'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        ack, busy, init_done, psram_sck, psram_ce_n, sio_oe;
    logic [3:0]  sio_out;
    logic [3:0]  sio_in = 4'h0;

    qspi_psram_ctrl #(
        .CLK_DIV(CLK_DIV), .RD_WAIT(RD_WAIT), .CE_GAP(CE_GAP), .INIT_DLY(INIT_DLY)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .busy(busy), .init_done(init_done),
        .psram_sck(psram_sck), .psram_ce_n(psram_ce_n),
        .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // PSRAM model / bus monitor state, all owned by the single monitor process
    logic [7:0]  tr_cmd   [0:63];
    int          tr_rises [0:63];
    logic [23:0] tr_adr   [0:63];
    logic [31:0] tr_data  [0:63];
    int          tr_oebad [0:63];
    int          tr_cnt = 0;
    logic [7:0]  cur_cmd = 8'h0;
    int          cur_rc = 0;
    logic [23:0] cur_adr = 24'h0;
    logic [31:0] cur_data = 32'h0;
    int          cur_oebad = 0;
    bit          in_tr = 0;
    int          clk_cnt = 0, end_time = 0, last_gap = 0, min_gap = 1000000;
    bit          have_end = 0;
    int          ack_cnt = 0, early_ack = 0, sck_bad = 0;
    logic        ce_prev = 1'b1, sck_prev = 1'b0;
    logic [7:0]  mem [logic [23:0]];

    function automatic logic [3:0] mem_nib(input logic [23:0] a, input int k);
        logic [23:0] ba;
        logic [7:0]  b;
        ba = a + 24'(k / 2);
        b  = mem.exists(ba) ? mem[ba] : 8'h00;
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            clk_cnt++;
            if (ack) begin
                ack_cnt++;
                if (!init_done) early_ack++;
            end
            if (ce_prev && !psram_ce_n) begin
                in_tr = 1; cur_cmd = 8'h0; cur_rc = 0; cur_adr = 24'h0;
                cur_data = 32'h0; cur_oebad = 0;
                if (have_end) begin
                    last_gap = clk_cnt - end_time;
                    if (last_gap < min_gap) min_gap = last_gap;
                end
            end
            if (!sck_prev && psram_sck) begin
                if (psram_ce_n) sck_bad++;
                cur_rc++;
                if (cur_rc <= 8) begin
                    cur_cmd = {cur_cmd[6:0], sio_out[0]};
                    if (!sio_oe || sio_out[3:1] != 3'b000) cur_oebad++;
                end else if (cur_rc <= 14) begin
                    cur_adr = {cur_adr[19:0], sio_out};
                    if (!sio_oe) cur_oebad++;
                end else if (cur_cmd == 8'h38) begin
                    cur_data = {cur_data[27:0], sio_out};
                    if (!sio_oe) cur_oebad++;
                end else if (sio_oe) begin
                    cur_oebad++;
                end
            end
            if (sck_prev && !psram_sck && !psram_ce_n && cur_cmd == 8'hEB &&
                cur_rc >= 8 + 6 + RD_WAIT && cur_rc < 8 + 6 + RD_WAIT + 8)
                sio_in = mem_nib(cur_adr, cur_rc - (8 + 6 + RD_WAIT));
            if (!ce_prev && psram_ce_n && in_tr) begin
                tr_cmd[tr_cnt]   = cur_cmd;
                tr_rises[tr_cnt] = cur_rc;
                tr_adr[tr_cnt]   = cur_adr;
                tr_data[tr_cnt]  = cur_data;
                tr_oebad[tr_cnt] = cur_oebad;
                if (cur_cmd == 8'h38 && cur_rc == 22) begin
                    mem[cur_adr]         = cur_data[31:24];
                    mem[cur_adr + 24'd1] = cur_data[23:16];
                    mem[cur_adr + 24'd2] = cur_data[15:8];
                    mem[cur_adr + 24'd3] = cur_data[7:0];
                end
                tr_cnt++;
                end_time = clk_cnt; have_end = 1; in_tr = 0; sio_in = 4'h0;
            end
            ce_prev  = psram_ce_n;
            sck_prev = psram_sck;
        end
    end

    task automatic wait_ack(input string tag, input bit drop, output logic [31:0] rd);
        bit seen;
        seen = 0;
        rd = 32'h0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                seen = 1;
                rd = rdata;
                if (drop) req = 1'b0;
            end
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        $display("txn %s: we=%0d adr=0x%06h ack=%0d rdata=0x%08h", tag, we, adr, seen, rd);
    endtask

    task automatic wait_init(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(posedge clk); #1;
            if (init_done) seen = 1;
        end
        check({tag, "_init_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic settle();
        repeat (CE_GAP + 6) @(posedge clk);
        #1;
    endtask

    task automatic check_read(input string tag, input int idx, input logic [31:0] rd,
                              input logic [31:0] exp_data);
        check({tag, "_rdata"}, rd, exp_data);
        check({tag, "_cmd"},   32'(tr_cmd[idx]), 32'h0000_00EB);
        check({tag, "_rises"}, 32'(tr_rises[idx]), 32'(8 + 6 + RD_WAIT + 8));
        check({tag, "_adr"},   32'(tr_adr[idx]), 32'h0000_0104);
        check({tag, "_oe"},    32'(tr_oebad[idx]), 32'd0);
    endtask

    logic [31:0] rd;
    int base_ack, base_tr;
    bit reached;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", rdata, 32'h0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_sck", 32'(psram_sck), 32'd0);
        check("rst_ce_n", 32'(psram_ce_n), 32'd1);
        check("rst_sio_out", 32'(sio_out), 32'd0);
        check("rst_sio_oe", 32'(sio_oe), 32'd0);

        // Request raised right at reset release must wait for the init sequence
        rst = 1'b0; req = 1'b1; we = 1'b1; adr = 24'h000104; wdata = 32'hA5C33C5A;
        wait_init("init");
        check("init_tr_count", 32'(tr_cnt), 32'd2);
        check("init_rsten_cmd", 32'(tr_cmd[0]), 32'h66);
        check("init_rsten_len", 32'(tr_rises[0]), 32'd8);
        check("init_rst_cmd", 32'(tr_cmd[1]), 32'h99);
        check("init_rst_len", 32'(tr_rises[1]), 32'd8);
        check("init_gap", 32'(last_gap >= CE_GAP), 32'd1);
        check("init_early_ack", 32'(early_ack), 32'd0);

        base_ack = ack_cnt;
        wait_ack("wr_104", 1'b1, rd);
        settle();
        check("wr_single_ack", 32'(ack_cnt - base_ack), 32'd1);
        check("wr_cmd", 32'(tr_cmd[2]), 32'h38);
        check("wr_rises", 32'(tr_rises[2]), 32'd22);
        check("wr_adr", 32'(tr_adr[2]), 32'h000104);
        check("wr_data_nibbles", tr_data[2], 32'h5A3CC3A5);
        check("wr_oe", 32'(tr_oebad[2]), 32'd0);

        req = 1'b1; we = 1'b0; adr = 24'h000104;
        wait_ack("rd_104", 1'b1, rd);
        settle();
        check_read("rd_104", 3, rd, 32'hA5C33C5A);

        req = 1'b1; we = 1'b0; adr = 24'h000107;
        wait_ack("rd_107", 1'b1, rd);
        settle();
        check_read("rd_107", 4, rd, 32'hA5C33C5A);

        // Write then read with req held high across the first ack
        base_ack = ack_cnt;
        req = 1'b1; we = 1'b1; adr = 24'h000200; wdata = 32'h12345678;
        wait_ack("b2b_wr", 1'b0, rd);
        we = 1'b0;
        wait_ack("b2b_rd", 1'b1, rd);
        settle();
        check("b2b_rdata", rd, 32'h12345678);
        check("b2b_acks", 32'(ack_cnt - base_ack), 32'd2);
        check("b2b_tr_count", 32'(tr_cnt), 32'd7);
        check("b2b_first_cmd", 32'(tr_cmd[5]), 32'h38);
        check("b2b_second_cmd", 32'(tr_cmd[6]), 32'hEB);
        check("b2b_gap", 32'(last_gap >= CE_GAP), 32'd1);

        // Reset in the middle of the read data phase
        base_tr = tr_cnt;
        req = 1'b1; we = 1'b0; adr = 24'h000104;
        reached = 0;
        for (int i = 0; i < 2000 && !reached; i++) begin
            @(posedge clk); #1;
            if (in_tr && cur_rc >= 8 + 6 + RD_WAIT + 2) reached = 1;
        end
        check("abort_rdat_reached", 32'(reached), 32'd1);
        base_ack = ack_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ce_n", 32'(psram_ce_n), 32'd1);
        check("abort_sck", 32'(psram_sck), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_init_done", 32'(init_done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0;
        wait_init("reinit");
        check("reinit_no_ack", 32'(ack_cnt - base_ack), 32'd0);
        check("reinit_tr_count", 32'(tr_cnt - base_tr), 32'd3);
        check("abort_partial", 32'(tr_rises[base_tr] < 28), 32'd1);
        check("reinit_rsten_cmd", 32'(tr_cmd[base_tr + 1]), 32'h66);
        check("reinit_rst_cmd", 32'(tr_cmd[base_tr + 2]), 32'h99);

        check("min_ce_gap", 32'(min_gap >= CE_GAP), 32'd1);
        check("sck_only_in_ce", 32'(sck_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
